// File: rtl/ibis_vga_pattern_gen.sv
// Frame-synchronous VGA test-pattern generator: XOR, bars, checker, ramp, solid.
// Two-stage colour pipeline with syncs/DE delayed alongside so outputs stay aligned.
module ibis_vga_pattern_gen #(
   parameter int WIDTH       = 10,
   parameter int BAR_SHIFT   = 6,
   parameter int CHECK_SHIFT = 5
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             enable,
   input  logic [WIDTH-1:0] ord_x,
   input  logic [WIDTH-1:0] ord_y,
   input  logic             de_in,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic [2:0]       mode_in,
   input  logic             mode_load,
   input  logic             scroll_en,
   input  logic [23:0]      fill_rgb,
   output logic [7:0]       red,
   output logic [7:0]       grn,
   output logic [7:0]       blu,
   output logic             de_out,
   output logic             hsync_out,
   output logic             vsync_out,
   output logic [7:0]       frame_count
);

   logic [2:0]       r_p_mode, r_mode;
   logic             r_p_scroll, r_scroll, r_p_valid;
   logic [23:0]      r_p_fill, r_fill;
   logic [7:0]       r_fc;

   logic [WIDTH-1:0] r_s1_sx, r_s1_y;
   logic             r_s1_de, r_s1_hs, r_s1_vs;
   logic [23:0]      r_rgb;
   logic             r_de, r_hs, r_vs;

   logic             w_sof;
   logic [2:0]       w_nx_mode;
   logic             w_nx_scroll, w_scroll_cur;
   logic [23:0]      w_nx_fill;
   logic [WIDTH-1:0] w_sx;
   logic [2:0]       w_bar, w_k;
   logic             w_chk;
   logic [23:0]      w_rgb;
   logic             w_unused;

   assign w_sof = enable & de_in & (ord_x == '0) & (ord_y == '0);

   // A load in the SOF cycle wins over an older pending request.
   assign w_nx_mode   = mode_load ? mode_in   : (r_p_valid ? r_p_mode   : r_mode);
   assign w_nx_scroll = mode_load ? scroll_en : (r_p_valid ? r_p_scroll : r_scroll);
   assign w_nx_fill   = mode_load ? fill_rgb  : (r_p_valid ? r_p_fill   : r_fill);

   // Pixel (0,0) already uses the incoming configuration.
   assign w_scroll_cur = w_sof ? w_nx_scroll : r_scroll;
   assign w_sx         = ord_x + (w_scroll_cur ? WIDTH'(r_fc) : '0);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_p_mode   <= '0;
         r_p_scroll <= 1'b0;
         r_p_fill   <= '0;
         r_p_valid  <= 1'b0;
         r_mode     <= '0;
         r_scroll   <= 1'b0;
         r_fill     <= '0;
         r_fc       <= '0;
      end else begin
         if (mode_load) begin
            r_p_mode   <= mode_in;
            r_p_scroll <= scroll_en;
            r_p_fill   <= fill_rgb;
         end
         if (w_sof) begin
            r_mode    <= w_nx_mode;
            r_scroll  <= w_nx_scroll;
            r_fill    <= w_nx_fill;
            r_fc      <= r_fc + 8'd1;
            r_p_valid <= 1'b0;
         end else if (mode_load) begin
            r_p_valid <= 1'b1;
         end
      end
   end

   assign w_bar = r_s1_sx[BAR_SHIFT+2:BAR_SHIFT];
   assign w_k   = ~w_bar;
   assign w_chk = r_s1_sx[CHECK_SHIFT] ^ r_s1_y[CHECK_SHIFT];

   // High raster bits feed no pattern; folded here so they count as consumed.
   assign w_unused = ^{r_s1_sx, r_s1_y};

   always_comb begin
      w_rgb = '0;
      if (r_s1_de) begin
         case (r_mode)
            3'd0:    w_rgb = {r_s1_sx[7:0], r_s1_y[7:0], r_s1_sx[7:0] ^ r_s1_y[7:0]};
            3'd1:    w_rgb = {{8{w_k[2]}}, {8{w_k[1]}}, {8{w_k[0]}}};
            3'd2:    w_rgb = {24{w_chk}};
            3'd3:    w_rgb = {3{r_s1_sx[7:0]}};
            3'd4:    w_rgb = r_fill;
            default: w_rgb = '0;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_s1_sx <= '0;
         r_s1_y  <= '0;
         r_s1_de <= 1'b0;
         r_s1_hs <= 1'b0;
         r_s1_vs <= 1'b0;
         r_rgb   <= '0;
         r_de    <= 1'b0;
         r_hs    <= 1'b0;
         r_vs    <= 1'b0;
      end else if (enable) begin
         r_s1_sx <= w_sx;
         r_s1_y  <= ord_y;
         r_s1_de <= de_in;
         r_s1_hs <= hsync_in;
         r_s1_vs <= vsync_in;
         r_rgb   <= w_rgb;
         r_de    <= r_s1_de;
         r_hs    <= r_s1_hs;
         r_vs    <= r_s1_vs;
      end
   end

   assign red         = r_rgb[23:16];
   assign grn         = r_rgb[15:8];
   assign blu         = r_rgb[7:0];
   assign de_out      = r_de;
   assign hsync_out   = r_hs;
   assign vsync_out   = r_vs;
   assign frame_count = r_fc;

endmodule

// File: tb/tb_ibis_vga_pattern_gen.sv
// Bench for ibis_vga_pattern_gen: directed plan items plus random traffic,
// all compared against a pixel-function model with a two-deep output queue.
module tb_ibis_vga_pattern_gen;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        enable = 1'b0;
   logic [9:0]  ord_x = '0, ord_y = '0;
   logic        de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
   logic [2:0]  mode_in = '0;
   logic        mode_load = 1'b0, scroll_en = 1'b0;
   logic [23:0] fill_rgb = '0;
   logic [7:0]  red, grn, blu, frame_count;
   logic        de_out, hsync_out, vsync_out;

   ibis_vga_pattern_gen dut (
      .aclk(aclk), .aresetn(aresetn), .enable(enable),
      .ord_x(ord_x), .ord_y(ord_y), .de_in(de_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .mode_in(mode_in), .mode_load(mode_load), .scroll_en(scroll_en),
      .fill_rgb(fill_rgb),
      .red(red), .grn(grn), .blu(blu),
      .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
      .frame_count(frame_count)
   );

   always #5 aclk = ~aclk;

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // Reference state: active/pending configuration and frame counter.
   int          m_fc = 0, m_mode = 0, m_fill = 0, p_mode = 0, p_fill = 0;
   bit          m_scroll = 0, p_scroll = 0, p_valid = 0;
   logic [26:0] q_s1 = '0, q_out = '0;

   function automatic logic [23:0] pix(int x, int y, bit de, int mode, bit sc, int fill, int fc);
      int sx, bar;
      if (!de) return 24'h0;
      sx = (x + (sc ? fc : 0)) % 1024;
      case (mode)
         0: return {8'(sx % 256), 8'(y % 256), 8'((sx ^ y) % 256)};
         1: begin
            bar = (sx / 64) % 8;
            return {(bar < 4) ? 8'hFF : 8'h00, ((bar % 4) < 2) ? 8'hFF : 8'h00,
                    ((bar % 2) == 0) ? 8'hFF : 8'h00};
         end
         2: return (((sx / 32) + (y / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
         3: return {3{8'(sx % 256)}};
         4: return 24'(fill);
         default: return 24'h0;
      endcase
   endfunction

   task automatic tick();
      bit sof, es;
      int em, ef;
      if (!aresetn) begin
         m_fc = 0; m_mode = 0; m_fill = 0; m_scroll = 0;
         p_mode = 0; p_fill = 0; p_scroll = 0; p_valid = 0;
         q_s1 = '0; q_out = '0;
      end else begin
         sof = enable && de_in && ord_x == 0 && ord_y == 0;
         em = m_mode; es = m_scroll; ef = m_fill;
         if (sof) begin
            if (mode_load) begin
               em = int'(mode_in); es = scroll_en; ef = int'(fill_rgb);
            end else if (p_valid) begin
               em = p_mode; es = p_scroll; ef = p_fill;
            end
         end
         if (enable) begin
            q_out = q_s1;
            q_s1  = {pix(int'(ord_x), int'(ord_y), de_in, em, es, ef, m_fc),
                     de_in, hsync_in, vsync_in};
         end
         if (mode_load) begin
            p_mode = int'(mode_in); p_scroll = scroll_en; p_fill = int'(fill_rgb); p_valid = 1;
         end
         if (sof) begin
            m_mode = em; m_scroll = es; m_fill = ef;
            m_fc = (m_fc + 1) % 256;
            p_valid = 0;
         end
      end
      @(posedge aclk);
      #1;
      chk("pixel", 32'({red, grn, blu, de_out, hsync_out, vsync_out}), 32'(q_out));
      chk("frame_count", 32'(frame_count), 32'(m_fc));
   endtask

   task automatic px(input logic [9:0] x, input logic [9:0] y, input bit de);
      ord_x = x; ord_y = y; de_in = de;
      tick();
   endtask

   // Drive one pixel, then a blank filler so that pixel reaches the output.
   task automatic px_out(input string tag, input logic [9:0] x, input logic [9:0] y,
                         input logic [23:0] exp);
      px(x, y, 1'b1);
      px(10'd1, 10'd1, 1'b0);
      chk(tag, 32'({red, grn, blu}), 32'(exp));
   endtask

   task automatic load(input logic [2:0] m, input bit sc, input logic [23:0] f);
      mode_in = m; scroll_en = sc; fill_rgb = f; mode_load = 1'b1;
      px(10'd7, 10'd7, 1'b1);
      mode_load = 1'b0;
   endtask

   initial begin
      repeat (4) tick();
      chk("rst_out", 32'({red, grn, blu, de_out, hsync_out, vsync_out}), 32'h0);
      chk("rst_fc", 32'(frame_count), 32'h0);
      aresetn = 1'b1;
      enable  = 1'b1;

      px_out("xor_default", 10'h0A5, 10'h03C, 24'hA53C99);

      load(3'd1, 1'b0, 24'h0);
      px_out("bar0", 10'd0, 10'd0, 24'hFFFFFF);
      px_out("bar1", 10'd64, 10'd0, 24'hFFFF00);
      px_out("bar7", 10'd448, 10'd0, 24'h000000);
      px(10'd64, 10'd5, 1'b0);
      px(10'd1, 10'd1, 1'b0);
      chk("blank", 32'({red, grn, blu, de_out}), 32'h0);

      load(3'd0, 1'b0, 24'h0);
      px(10'd0, 10'd0, 1'b1);
      load(3'd2, 1'b0, 24'h0);
      px_out("defer_old", 10'd5, 10'd3, 24'h050306);
      px(10'd0, 10'd0, 1'b1);
      px_out("chk_32_0", 10'd32, 10'd0, 24'hFFFFFF);
      px_out("chk_32_32", 10'd32, 10'd32, 24'h000000);
      mode_in = 3'd4; scroll_en = 1'b0; fill_rgb = 24'h123456; mode_load = 1'b1;
      px(10'd0, 10'd0, 1'b1);
      mode_load = 1'b0;
      px(10'd1, 10'd1, 1'b0);
      chk("coinc_solid", 32'({red, grn, blu}), 32'h123456);
      load(3'd6, 1'b0, 24'hABCDEF);
      px(10'd0, 10'd0, 1'b1);
      px_out("reserved", 10'd77, 10'd9, 24'h0);

      enable = 1'b0;
      mode_in = 3'd2; mode_load = 1'b1;
      tick();
      mode_load = 1'b0;
      enable = 1'b1;
      px(10'd0, 10'd0, 1'b1);
      px_out("en_low_load", 10'd32, 10'd0, 24'hFFFFFF);
      for (int i = 0; i < 300; i++) begin
         enable = (i % 3 == 0);
         ord_x = ($urandom % 5 == 0) ? 10'd0 : 10'($urandom);
         ord_y = ($urandom % 5 == 0) ? 10'd0 : 10'($urandom);
         de_in = ($urandom % 4 != 0);
         hsync_in = 1'($urandom); vsync_in = 1'($urandom);
         tick();
      end
      enable = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;

      load(3'd3, 1'b1, 24'h0);
      for (int f = 0; f < 260; f++) begin
         bool_wrap: begin
            bit wrap;
            wrap = (m_fc == 255);
            px(10'd0, 10'd0, 1'b1);
            if (wrap) chk("fc_wrap", 32'(frame_count), 32'h0);
         end
         if (m_fc == 200) px_out("scroll_200", 10'd100, 10'd5, 24'h2C2C2C);
         else px(10'd100, 10'd5, 1'b1);
      end

      for (int i = 0; i < 1500; i++) begin
         enable = ($urandom % 4 != 0);
         ord_x = ($urandom % 6 == 0) ? 10'd0 : 10'($urandom);
         ord_y = ($urandom % 6 == 0) ? 10'd0 : 10'($urandom);
         de_in = ($urandom % 5 != 0);
         hsync_in = 1'($urandom); vsync_in = 1'($urandom);
         mode_load = ($urandom % 12 == 0);
         mode_in = 3'($urandom); scroll_en = 1'($urandom); fill_rgb = 24'($urandom);
         aresetn = ($urandom % 300 != 0);
         tick();
      end
      aresetn = 1'b1; mode_load = 1'b0; enable = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;

      load(3'd3, 1'b0, 24'h0);
      px(10'd0, 10'd0, 1'b1);
      px(10'd50, 10'd2, 1'b1);
      px(10'd51, 10'd2, 1'b1);
      aresetn = 1'b0; mode_load = 1'b1; mode_in = 3'd5;
      px(10'd0, 10'd0, 1'b1);
      chk("midrst_out", 32'({red, grn, blu, de_out, hsync_out, vsync_out}), 32'h0);
      chk("midrst_fc", 32'(frame_count), 32'h0);
      aresetn = 1'b1; mode_load = 1'b0;
      px_out("post_rst_mode0", 10'h0A5, 10'h03C, 24'hA53C99);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
